// File: rtl/shared_reg_pkg.sv
// rtl/shared_reg_pkg.sv - command and state encodings shared by the register arbiter files
package shared_reg_pkg;

  localparam logic [1:0] CMD_LOAD   = 2'b00;
  localparam logic [1:0] CMD_CLEAR  = 2'b01;
  localparam logic [1:0] CMD_SET    = 2'b10;
  localparam logic [1:0] CMD_TOGGLE = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GRANT  = 2'b01,
    COMMIT = 2'b10
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker, scans upward from ptr with wrap
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int PW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] winner_oh,
  output logic [PW-1:0]    winner_idx,
  output logic             any_req
);

  logic [PW:0]   sum;
  logic [PW-1:0] idx;

  always_comb begin
    winner_oh  = '0;
    winner_idx = '0;
    any_req    = 1'b0;
    sum        = '0;
    idx        = '0;
    for (int off = 0; off < N_REQ; off++) begin
      // ptr + off stays below 2*N_REQ, so a single subtract performs the wrap
      sum = {1'b0, ptr} + (PW+1)'(off);
      if (sum >= (PW+1)'(N_REQ))
        sum = sum - (PW+1)'(N_REQ);
      idx = sum[PW-1:0];
      if (!any_req && req[idx]) begin
        any_req        = 1'b1;
        winner_oh[idx] = 1'b1;
        winner_idx     = idx;
      end
    end
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// rtl/shared_reg_arbiter.sv - round-robin shared register with LOAD/CLEAR/SET/TOGGLE commands
// Optional macro SHARED_REG_LOCK_EN adds a per-requester lock for back-to-back ownership.
module shared_reg_arbiter
  import shared_reg_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [2*N_REQ-1:0]     cmd,
  input  logic [WIDTH*N_REQ-1:0] din,
`ifdef SHARED_REG_LOCK_EN
  input  logic [N_REQ-1:0]       lock,
`endif
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       ack,
  output logic [WIDTH-1:0]       q,
  output logic                   busy
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t           state, state_nxt;
  logic [PW-1:0]    ptr, ptr_nxt, win, win_nxt;
  logic [1:0]       cap_cmd, cap_cmd_nxt;
  logic [WIDTH-1:0] cap_din, cap_din_nxt, q_nxt;
  logic [N_REQ-1:0] gnt_nxt, ack_nxt;
  logic [N_REQ-1:0] pick_oh;
  logic [PW-1:0]    pick_idx;
  logic             any_req;
  logic             lock_win;

  logic [1:0]       cmd_arr [N_REQ];
  logic [WIDTH-1:0] din_arr [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign cmd_arr[i] = cmd[2*i +: 2];
    assign din_arr[i] = din[WIDTH*i +: WIDTH];
  end

`ifdef SHARED_REG_LOCK_EN
  assign lock_win = lock[win];
`else
  assign lock_win = 1'b0;
`endif

  rr_arbiter #(.N_REQ(N_REQ), .PW(PW)) u_rr (
    .req        (req),
    .ptr        (ptr),
    .winner_oh  (pick_oh),
    .winner_idx (pick_idx),
    .any_req    (any_req)
  );

  function automatic logic [WIDTH-1:0] apply_cmd(input logic [1:0] c,
                                                 input logic [WIDTH-1:0] cur,
                                                 input logic [WIDTH-1:0] d);
    case (c)
      CMD_LOAD:  return d;
      CMD_CLEAR: return '0;
      CMD_SET:   return '1;
      default:   return ~cur;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      win     <= '0;
      cap_cmd <= '0;
      cap_din <= '0;
      q       <= '0;
      gnt     <= '0;
      ack     <= '0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      win     <= win_nxt;
      cap_cmd <= cap_cmd_nxt;
      cap_din <= cap_din_nxt;
      q       <= q_nxt;
      gnt     <= gnt_nxt;
      ack     <= ack_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    win_nxt     = win;
    cap_cmd_nxt = cap_cmd;
    cap_din_nxt = cap_din;
    q_nxt       = q;
    gnt_nxt     = gnt;
    ack_nxt     = '0;
    case (state)
      IDLE: begin
        if (any_req) begin
          win_nxt     = pick_idx;
          gnt_nxt     = pick_oh;
          cap_cmd_nxt = cmd_arr[pick_idx];
          cap_din_nxt = din_arr[pick_idx];
          state_nxt   = GRANT;
        end
      end
      GRANT: begin
        // a dropped request aborts without touching q or the pointer
        if (req[win]) begin
          state_nxt = COMMIT;
        end else begin
          gnt_nxt   = '0;
          state_nxt = IDLE;
        end
      end
      COMMIT: begin
        q_nxt   = apply_cmd(cap_cmd, q, cap_din);
        ack_nxt = gnt;
        if (lock_win) begin
          cap_cmd_nxt = cmd_arr[win];
          cap_din_nxt = din_arr[win];
          state_nxt   = GRANT;
        end else begin
          gnt_nxt   = '0;
          ptr_nxt   = (win == PW'(N_REQ-1)) ? '0 : win + 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        gnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  assign busy = (state != IDLE);

endmodule
